// File: rtl/hamming_pkg.sv
// Shared types and position helpers for the Hamming SEC encoder/decoder pair.
package hamming_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} enc_state_t;

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Codeword position (1-based) of the i-th data bit, counting data slots in ascending order.
  function automatic int data_pos(input int i);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int p = 1; p <= 4096; p++) begin
      if (pos == 0 && !is_pow2(p)) begin
        if (seen == i) pos = p;
        seen = seen + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_encoder_if.sv
// Input/output handshake bundle of the Hamming encoder.
interface hamming_encoder_if #(
  parameter int unsigned K = 26,
  parameter int unsigned P = 5
);
  localparam int unsigned N = K + P;

  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] data_in;
  logic [P-1:0] inj_pos;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] code_out;

  modport master (
    output in_valid, data_in, inj_pos, out_ready,
    input  in_ready, out_valid, code_out
  );

  modport slave (
    input  in_valid, data_in, inj_pos, out_ready,
    output in_ready, out_valid, code_out
  );
endinterface

// File: rtl/hamming_scatter.sv
// Places K data bits into the non-power-of-two codeword positions; parity slots read as zero.
module hamming_scatter
  import hamming_pkg::*;
#(
  parameter int unsigned K = 26,
  parameter int unsigned N = 31
) (
  input  logic [K-1:0] data,
  output logic [N-1:0] word_c
);

  // data MSB lands on the lowest data position (p=3); position p is bit N-p
  for (genvar gi = 0; gi < K; gi++) begin : g_data
    localparam int unsigned POS = data_pos(gi);
    assign word_c[N-POS] = data[K-1-gi];
  end

  for (genvar gp = 1; gp <= N; gp++) begin : g_slot
    if (is_pow2(gp)) begin : g_par
      assign word_c[N-gp] = 1'b0;
    end
  end

endmodule

// File: rtl/hamming_encoder.sv
// Hamming SEC encoder: accepts a data word, fills one parity slot per cycle, optionally flips one bit.
module hamming_encoder
  import hamming_pkg::*;
#(
  parameter int unsigned K = 26,
  parameter int unsigned P = 5
) (
  input logic              clk,
  input logic              rst_n,
  hamming_encoder_if.slave bus
);

  localparam int unsigned N  = K + P;
  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  if ((32'd1 << P) < K + P + 1) begin : g_bad_cfg
    $error("hamming_encoder: 2**P must be >= K+P+1");
  end

  enc_state_t    state;
  enc_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  word;
  logic [P-1:0]  inj;
  logic [N-1:0]  scat_c;
  logic [N-1:0]  word_upd_c;
  logic [N-1:0]  inj_mask_c;
  logic [P-1:0]  par_c;
  logic          last_c;

  hamming_scatter #(.K(K), .N(N)) u_scatter (
    .data   (bus.data_in),
    .word_c (scat_c)
  );

  // Parity k covers every data position whose index has bit k set.
  for (genvar gk = 0; gk < P; gk++) begin : g_par
    logic [K-1:0] sel;
    for (genvar gi = 0; gi < K; gi++) begin : g_sel
      localparam int unsigned POS = data_pos(gi);
      if (((POS >> gk) & 1) != 0) begin : g_on
        assign sel[gi] = word[N-POS];
      end else begin : g_off
        assign sel[gi] = 1'b0;
      end
    end
    assign par_c[gk] = ^sel;
  end

  always_comb begin : upd_comb
    word_upd_c = word;
    word_upd_c[IW'(N - (32'd1 << cnt))] = par_c[cnt];
  end

  // Out-of-range injection positions leave the codeword untouched.
  always_comb begin : inj_comb
    inj_mask_c = '0;
    if (inj != '0 && 32'(inj) <= N) inj_mask_c[IW'(N - 32'(inj))] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin : next_comb
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = CALC;
      CALC:    if (last_c)        state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin : out_comb
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    last_c        = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      CALC:    last_c        = (cnt == CW'(P - 1));
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : data_reg
    if (!rst_n) begin
      word         <= '0;
      inj          <= '0;
      cnt          <= '0;
      bus.code_out <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          word <= scat_c;
          inj  <= bus.inj_pos;
          cnt  <= '0;
        end
        CALC: begin
          word <= word_upd_c;
          if (last_c) bus.code_out <= word_upd_c ^ inj_mask_c;
          else        cnt          <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_encoder.sv
// Self-checking bench: vector tables, scoreboarded random traffic, backpressure and reset corners.
module tb_hamming_encoder;

  localparam int unsigned K   = 26;
  localparam int unsigned P   = 5;
  localparam int unsigned N   = K + P;
  localparam int unsigned KS  = 4;
  localparam int unsigned PS  = 3;
  localparam int unsigned NS  = KS + PS;
  localparam int unsigned KW  = $clog2(K);
  localparam int unsigned NW  = $clog2(N);
  localparam int unsigned SW  = $clog2(N + 1);

  typedef struct packed {
    logic [K-1:0] data;
    logic [P-1:0] inj;
    logic [N-1:0] code;
  } vec_t;

  typedef struct packed {
    logic [KS-1:0] data;
    logic [PS-1:0] inj;
    logic [NS-1:0] code;
  } svec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hamming_encoder_if #(.K(K),  .P(P))  bus ();
  hamming_encoder_if #(.K(KS), .P(PS)) sbus ();

  hamming_encoder #(.K(K),  .P(P))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  hamming_encoder #(.K(KS), .P(PS)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

  int    n_checks = 0;
  int    n_fail   = 0;
  int    ready_mode = 0;  // 0: ready high, 1: ready low, 2: random
  vec_t  sb_q[$];
  svec_t ssb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: walk positions, drop data into non-power-of-two slots, then fill parity.
  function automatic logic [N-1:0] model_enc(input logic [K-1:0] d);
    logic [N:1]   cw;
    logic [N-1:0] r;
    logic         par;
    int           j;
    cw = '0;
    j  = K - 1;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[SW'(p)] = d[KW'(j)];
        j--;
      end
    end
    for (int k = 0; k < P; k++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++)
        if (((p >> k) & 1) != 0 && p != (1 << k)) par ^= cw[SW'(p)];
      cw[SW'(1 << k)] = par;
    end
    for (int p = 1; p <= N; p++) r[NW'(N - p)] = cw[SW'(p)];
    return r;
  endfunction

  // Reference decoder: syndrome = XOR of set positions, correct one bit, gather data.
  function automatic logic [K-1:0] model_dec(input logic [N-1:0] c);
    logic [N-1:0]  w;
    logic [SW-1:0] syn;
    logic [K-1:0]  d;
    int            j;
    w   = c;
    syn = '0;
    for (int p = 1; p <= N; p++) if (w[NW'(N - p)]) syn ^= SW'(p);
    if (syn != '0) w[NW'(N - int'(syn))] = ~w[NW'(N - int'(syn))];
    j = K - 1;
    d = '0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[KW'(j)] = w[NW'(N - p)];
        j--;
      end
    end
    return d;
  endfunction

  function automatic logic [N-1:0] expect_code(input logic [K-1:0] d, input logic [P-1:0] ip);
    logic [N-1:0] e;
    e = model_enc(d);
    if (ip != '0) e[NW'(N - int'(ip))] = ~e[NW'(N - int'(ip))];
    return e;
  endfunction

  task automatic send(input logic [K-1:0] d, input logic [P-1:0] ip, input logic [N-1:0] exp);
    vec_t v;
    int   t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    bus.data_in  = d;
    bus.inj_pos  = ip;
    bus.in_valid = 1'b1;
    v.data = d;
    v.inj  = ip;
    v.code = exp;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data_in  = K'($urandom);
    bus.inj_pos  = P'($urandom);
  endtask

  task automatic ssend(input logic [KS-1:0] d, input logic [PS-1:0] ip, input logic [NS-1:0] exp);
    svec_t v;
    int    t;
    t = 0;
    @(negedge clk);
    while (!sbus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!sbus.in_ready) begin
      check("s_accept_timeout", 64'd0, 64'd1);
      return;
    end
    sbus.data_in  = d;
    sbus.inj_pos  = ip;
    sbus.in_valid = 1'b1;
    v.data = d;
    v.inj  = ip;
    v.code = exp;
    ssb_q.push_back(v);
    @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    sbus.data_in  = KS'($urandom);
    sbus.inj_pos  = PS'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || ssb_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb_q.size() + ssb_q.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    vec_t         tbl[7];
    svec_t        stbl[5];
    logic [K-1:0] d;
    logic [P-1:0] ip;
    logic [N-1:0] e;

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.inj_pos   = '0;
    bus.out_ready = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.data_in   = '0;
    sbus.inj_pos   = '0;
    sbus.out_ready = 1'b1;

    tbl[0] = '{26'h000_0000,  5'd0, 31'h0000_0000};
    tbl[1] = '{26'h3FF_FFFF,  5'd0, 31'h7FFF_FFFF};
    tbl[2] = '{26'h000_0001,  5'd0, 31'h6880_8001};
    tbl[3] = '{26'h000_0001,  5'd1, 31'h2880_8001};
    tbl[4] = '{26'h000_0000, 5'd31, 31'h0000_0001};
    tbl[5] = '{26'h3FF_FFFF, 5'd16, 31'h7FFF_7FFF};
    tbl[6] = '{26'h200_0000,  5'd0, 31'h7000_0000};

    stbl[0] = '{4'b1011, 3'd0, 7'b0110011};
    stbl[1] = '{4'b1011, 3'd5, 7'b0110111};
    stbl[2] = '{4'b1011, 3'd7, 7'b0110010};
    stbl[3] = '{4'b0000, 3'd0, 7'b0000000};
    stbl[4] = '{4'b1111, 3'd0, 7'b1111111};

    fork
      begin : mon
        vec_t  me;
        svec_t se;
        forever begin
          @(negedge clk);
          if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected", 64'd1, 64'd0);
            else begin
              me = sb_q.pop_front();
              check("code_out", 64'(bus.code_out), 64'(me.code));
              check("decoded", 64'(model_dec(bus.code_out)), 64'(me.data));
              check("flip_count", 64'($countones(bus.code_out ^ model_enc(me.data))),
                    (me.inj != '0) ? 64'd1 : 64'd0);
            end
          end
          if (rst_n && sbus.out_valid && sbus.out_ready) begin
            if (ssb_q.size() == 0) check("s_sb_unexpected", 64'd1, 64'd0);
            else begin
              se = ssb_q.pop_front();
              check("s_code_out", 64'(sbus.code_out), 64'(se.code));
            end
          end
        end
      end
      begin : rdy
        forever begin
          @(posedge clk);
          #1;
          case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
          endcase
        end
      end
      begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    #2;
    check("rst_in_ready",    64'(bus.in_ready),   64'd1);
    check("rst_out_valid",   64'(bus.out_valid),  64'd0);
    check("rst_code_out",    64'(bus.code_out),   64'd0);
    check("rst_s_in_ready",  64'(sbus.in_ready),  64'd1);
    check("rst_s_out_valid", 64'(sbus.out_valid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Small config latency: out_valid rises exactly P edges after accept
    @(negedge clk);
    sbus.data_in  = 4'b1011;
    sbus.inj_pos  = 3'd0;
    sbus.in_valid = 1'b1;
    ssb_q.push_back('{4'b1011, 3'd0, 7'b0110011});
    @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    for (int e2 = 1; e2 <= 3; e2++) begin
      @(posedge clk);
      #1;
      check($sformatf("s_latency_e%0d", e2), 64'(sbus.out_valid), (e2 == 3) ? 64'd1 : 64'd0);
      check($sformatf("s_busy_e%0d", e2), 64'(sbus.in_ready), 64'd0);
    end

    for (int i = 0; i < 5; i++) ssend(stbl[i].data, stbl[i].inj, stbl[i].code);
    for (int i = 0; i < 7; i++) send(tbl[i].data, tbl[i].inj, tbl[i].code);
    drain();

    // Backpressure: hold DONE for 10 cycles with spurious in_valid pulses
    ready_mode = 1;
    repeat (2) @(negedge clk);
    d = 26'h155_AAAA;
    e = model_enc(d);
    send(d, '0, e);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_code_out", 64'(bus.code_out), 64'(e));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = (i % 2 == 0);
      bus.data_in  = K'($urandom);
    end
    bus.in_valid = 1'b0;
    ready_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_single_transfer",   64'(sb_q.size()),   64'd0);

    // Reset while in CALC at cnt=2
    d = 26'h2AB_CDEF;
    send(d, '0, model_enc(d));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    ssb_q.delete();
    #1;
    check("rst_calc_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_calc_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_calc_code_out",  64'(bus.code_out),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d = 26'h012_3456;
    send(d, '0, model_enc(d));
    drain();

    // Reset while held in DONE
    ready_mode = 1;
    repeat (2) @(negedge clk);
    d = 26'h3C3_C3C3;
    send(d, 5'd9, expect_code(d, 5'd9));
    wait_out_valid();
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    ssb_q.delete();
    #1;
    check("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_done_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_done_code_out",  64'(bus.code_out),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    d = 26'h0F0_0F0F;
    send(d, 5'd3, expect_code(d, 5'd3));
    drain();

    // Random traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      d  = K'($urandom);
      ip = P'($urandom_range(0, 31));
      send(d, ip, expect_code(d, ip));
    end
    drain();
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
